reloj_hms: RTL and testbench
============================

Name: reloj_hms

Overview:
Time-of-day core for the clock design. It consumes the 1 Hz enable pulse produced by the upstream seconds-prescaler/decade stage and cascades BCD seconds, minutes and hours. It also hosts the set-time state machine driven by two pre-synchronized buttons. Its BCD digit outputs feed the display multiplexer/7-segment stage downstream.

Parameters:
H_MOD, 24, hour modulus. Legal values are 24 (hours 00–23) or 12 (hours 00–11). Any other value is unsupported.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk-wide 1 Hz enable from upstream stage; high for exactly one clk
btn_mode  in  1  mode button, already synchronized and debounced, level
btn_inc  in  1  increment button, already synchronized and debounced, level
sec_u  out  4  seconds units, BCD 0–9
sec_t  out  4  seconds tens, BCD 0–5
min_u  out  4  minutes units, BCD 0–9
min_t  out  4  minutes tens, BCD 0–5
hr_u  out  4  hours units, BCD
hr_t  out  4  hours tens, BCD
editing  out  2  00 = RUN, 01 = SET_HR, 10 = SET_MIN (11 never driven)
blink  out  1  display blank strobe for the field being edited
day_tick  out  1  one-clk pulse on rollover to 00:00:00

Behaviour:
- Reset (rst_n low, asynchronous): all digits 0, state RUN, editing = 00, blink = 0, day_tick = 0, button-history flops 0. Release is synchronous to the next clk rising edge.
- Edge detect: mode_ev = btn_mode & ~btn_mode_q; inc_ev = btn_inc & ~btn_inc_q. History flops update every clk. Holding a button produces exactly one event.
- FSM:
  - RUN: mode_ev moves to SET_HR.
  - SET_HR: mode_ev moves to SET_MIN.
  - SET_MIN: mode_ev moves to RUN, and sec_u/sec_t clear to 0 on that same edge.
  - No other transitions.
- RUN counting, on the clk edge where tick = 1:
  - sec_u increments. At 9 it wraps to 0 and carries to sec_t.
  - sec_t wraps 5 to 0 and carries to min_u. min_u/min_t follow the same rules.
  - A minutes carry increments hours. When hours = H_MOD−1 (23 or 11), hours wrap to 00.
  - Hours are kept BCD: hr_u wraps 9 to 0 with hr_t+1.
  - All digits update in one cycle, so the display never shows an intermediate value.
- day_tick is registered. It is high for the single clk cycle following the edge on which the time went from (H_MOD−1):59:59 to 00:00:00.
- In RUN, inc_ev is ignored.
- In SET_HR / SET_MIN:
  - tick does not advance time. It toggles blink (blink starts at 0 on entry to a SET state).
  - inc_ev increments only the edited field, with wrap and no carry: hours wrap (H_MOD−1) to 00, minutes wrap 59 to 00.
  - Seconds hold their value.
- On entering RUN, blink is forced to 0.
- Simultaneous events in one cycle:
  - mode_ev and tick in RUN: the state transition wins and the tick is dropped (time does not advance).
  - mode_ev and inc_ev in a SET state: the transition wins and inc_ev is dropped.
  - tick and inc_ev in a SET state: both take effect (blink toggles, field increments).
- Reset mid-edit: returns to RUN at 00:00:00 immediately.
- Digits never hold non-BCD or out-of-range values in any state.

Test Plan:
- Reset/rollover: assert rst_n = 0 → all digits 0, editing = 00. Release, preload 23:59:58 via the set path, then apply 2 ticks → 23:59:59, then 00:00:00 with day_tick high for exactly one clk.
- Cascade: from 00:00:00 apply 3600 ticks → 01:00:00. Check 00:09:59 → 00:10:00 and 00:59:59 → 01:00:00 on single edges.
- Set path: mode_ev, then 13 inc_ev → hours 13. mode_ev, then 61 inc_ev → minutes 01 (wrap at 59). mode_ev → RUN, seconds 00. Ticks during SET leave time unchanged and toggle blink.
- Held button: btn_mode held high for 50 clks → only one transition (RUN → SET_HR).
- Collisions: mode_ev coincident with tick in RUN at 00:00:05 → editing = 01, seconds stay 05. inc_ev and tick together in SET_HR → hours+1 and blink toggles.
- H_MOD = 12: 11:59:59 + tick → 00:00:00. Set-hours wraps 11 → 00.

Source files
------------

// File: rtl/reloj_hms.sv
// Time-of-day core: BCD hh:mm:ss cascade on the 1 Hz tick, plus the
// two-button set-time machine (RUN -> SET_HR -> SET_MIN -> RUN).
module reloj_hms #(
  parameter int H_MOD = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic [3:0] min_t,
  output logic [3:0] hr_u,
  output logic [3:0] hr_t,
  output logic [1:0] editing,
  output logic       blink,
  output logic       day_tick
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0] ht;
    logic [3:0] hu;
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } hms_t;

  localparam logic [3:0] HT_MAX = 4'((H_MOD - 1) / 10);
  localparam logic [3:0] HU_MAX = 4'((H_MOD - 1) % 10);

  state_t state, state_nx;
  hms_t   t_q, t_d;
  logic   mode_q, inc_q, mode_ev, inc_ev;
  logic   blink_q, blink_d, day_q, day_d;
  logic   su_w, st_w, mu_w, mt_w, hr_max;

  // Digit advance; anything at or above max collapses to 0 so a digit
  // can never settle on an out-of-range value.
  function automatic logic [3:0] dig_nx(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [7:0] hr_nx(input logic [3:0] ht, input logic [3:0] hu);
    if (ht > HT_MAX || (ht == HT_MAX && hu >= HU_MAX)) return 8'h00;
    else if (hu >= 4'd9)                               return {ht + 4'd1, 4'd0};
    else                                               return {ht, hu + 4'd1};
  endfunction

  assign mode_ev = btn_mode & ~mode_q;
  assign inc_ev  = btn_inc  & ~inc_q;
  assign hr_max  = (t_q.ht == HT_MAX) && (t_q.hu == HU_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (mode_ev) state_nx = SET_HR;
      SET_HR:  if (mode_ev) state_nx = SET_MIN;
      SET_MIN: if (mode_ev) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Outputs
  always_comb begin
    editing  = state;
    blink    = blink_q;
    day_tick = day_q;
    sec_u    = t_q.su;
    sec_t    = t_q.st;
    min_u    = t_q.mu;
    min_t    = t_q.mt;
    hr_u     = t_q.hu;
    hr_t     = t_q.ht;
  end

  // Datapath: the whole carry chain resolves in one cycle.
  always_comb begin
    t_d     = t_q;
    blink_d = blink_q;
    day_d   = 1'b0;
    su_w    = t_q.su >= 4'd9;
    st_w    = su_w && (t_q.st >= 4'd5);
    mu_w    = st_w && (t_q.mu >= 4'd9);
    mt_w    = mu_w && (t_q.mt >= 4'd5);
    case (state)
      RUN: begin
        blink_d = 1'b0;
        if (tick && !mode_ev) begin
          t_d.su = dig_nx(t_q.su, 4'd9);
          if (su_w) t_d.st = dig_nx(t_q.st, 4'd5);
          if (st_w) t_d.mu = dig_nx(t_q.mu, 4'd9);
          if (mu_w) t_d.mt = dig_nx(t_q.mt, 4'd5);
          if (mt_w) {t_d.ht, t_d.hu} = hr_nx(t_q.ht, t_q.hu);
          day_d = mt_w && hr_max;
        end
      end
      SET_HR: begin
        if (mode_ev) blink_d = 1'b0;
        else begin
          if (tick)   blink_d = ~blink_q;
          if (inc_ev) {t_d.ht, t_d.hu} = hr_nx(t_q.ht, t_q.hu);
        end
      end
      SET_MIN: begin
        if (mode_ev) begin
          blink_d = 1'b0;
          t_d.st  = 4'd0;
          t_d.su  = 4'd0;
        end else begin
          if (tick) blink_d = ~blink_q;
          if (inc_ev) begin
            t_d.mu = dig_nx(t_q.mu, 4'd9);
            if (t_q.mu >= 4'd9) t_d.mt = dig_nx(t_q.mt, 4'd5);
          end
        end
      end
      default: begin
        t_d     = '0;
        blink_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      blink_q <= 1'b0;
      day_q   <= 1'b0;
      mode_q  <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      blink_q <= blink_d;
      day_q   <= day_d;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
    end
  end

endmodule

// File: tb/tb_reloj_hms.sv
// Directed bench for reloj_hms: vector table for the event interactions,
// hand sequences for set path, rollover, cascade, held button, H_MOD=12.
module tb_reloj_hms;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;

  logic [3:0] su, st, mu, mt, hu, ht;
  logic [1:0] ed;
  logic       bl, dt;
  logic [3:0] su2, st2, mu2, mt2, hu2, ht2;
  logic [1:0] ed2;
  logic       bl2, dt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reloj_hms #(.H_MOD(24)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_u(su), .sec_t(st), .min_u(mu), .min_t(mt), .hr_u(hu), .hr_t(ht),
    .editing(ed), .blink(bl), .day_tick(dt));

  reloj_hms #(.H_MOD(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_u(su2), .sec_t(st2), .min_u(mu2), .min_t(mt2), .hr_u(hu2), .hr_t(ht2),
    .editing(ed2), .blink(bl2), .day_tick(dt2));

  typedef struct {
    bit          t, m, i;
    logic [23:0] tm;
    logic [1:0]  ed;
    logic        bl;
    logic        dt;
  } vec_t;

  function automatic logic [23:0] tm24();
    return {ht, hu, mt, mu, st, su};
  endfunction

  function automatic logic [23:0] tm12();
    return {ht2, hu2, mt2, mu2, st2, su2};
  endfunction

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input bit t, input bit m, input bit i);
    @(negedge clk);
    tick = t; btn_mode = m; btn_inc = i;
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    cyc(0, 1, 0);
    cyc(0, 0, 0);
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 0; btn_mode = 0; btn_inc = 0;
    rst_n = 0;
    #3;
    rst_n = 1;
  endtask

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{1,0,0, 24'h000001, 2'd0, 0, 0};
    vecs[1]  = '{1,0,0, 24'h000002, 2'd0, 0, 0};
    vecs[2]  = '{0,0,0, 24'h000002, 2'd0, 0, 0};
    vecs[3]  = '{1,0,0, 24'h000003, 2'd0, 0, 0};
    vecs[4]  = '{1,0,0, 24'h000004, 2'd0, 0, 0};
    vecs[5]  = '{1,0,0, 24'h000005, 2'd0, 0, 0};
    vecs[6]  = '{1,1,0, 24'h000005, 2'd1, 0, 0};
    vecs[7]  = '{0,1,0, 24'h000005, 2'd1, 0, 0};
    vecs[8]  = '{0,0,0, 24'h000005, 2'd1, 0, 0};
    vecs[9]  = '{1,0,0, 24'h000005, 2'd1, 1, 0};
    vecs[10] = '{0,0,1, 24'h010005, 2'd1, 1, 0};
    vecs[11] = '{0,0,0, 24'h010005, 2'd1, 1, 0};
    vecs[12] = '{1,0,1, 24'h020005, 2'd1, 0, 0};
    vecs[13] = '{0,0,1, 24'h020005, 2'd1, 0, 0};
    vecs[14] = '{0,1,0, 24'h020005, 2'd2, 0, 0};
    vecs[15] = '{0,0,0, 24'h020005, 2'd2, 0, 0};
    vecs[16] = '{0,0,1, 24'h020105, 2'd2, 0, 0};
    vecs[17] = '{1,0,0, 24'h020105, 2'd2, 1, 0};
    vecs[18] = '{0,1,1, 24'h020100, 2'd0, 0, 0};
    vecs[19] = '{1,1,1, 24'h020101, 2'd0, 0, 0};
    vecs[20] = '{0,0,0, 24'h020101, 2'd0, 0, 0};
    vecs[21] = '{0,0,1, 24'h020101, 2'd0, 0, 0};

    // Reset state while rst_n is held low
    #12;
    chk("rst_time", tm24(), 24'h000000);
    chk("rst_edit", {22'd0, ed}, 24'd0);
    chk("rst_blink_day", {22'd0, bl, dt}, 24'd0);
    rst_n = 1;

    // Vector table
    for (int v = 0; v < 22; v++) begin
      cyc(vecs[v].t, vecs[v].m, vecs[v].i);
      chk($sformatf("vec%0d_time", v), tm24(), vecs[v].tm);
      chk($sformatf("vec%0d_edit", v), {22'd0, ed}, {22'd0, vecs[v].ed});
      chk($sformatf("vec%0d_blink", v), {23'd0, bl}, {23'd0, vecs[v].bl});
      chk($sformatf("vec%0d_day", v), {23'd0, dt}, {23'd0, vecs[v].dt});
    end

    // Held mode button: one transition only
    do_reset();
    for (int k = 0; k < 50; k++) cyc(0, 1, 0);
    chk("held_edit", {22'd0, ed}, 24'd1);
    cyc(0, 0, 0);
    chk("held_release_edit", {22'd0, ed}, 24'd1);

    // Asynchronous reset mid-edit
    press_inc(3);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midedit_rst_time", tm24(), 24'h000000);
    chk("midedit_rst_edit", {22'd0, ed}, 24'd0);
    #1 rst_n = 1;

    // Set path: 13 hours, 61 minute increments wrap to 01
    press_mode();
    press_inc(13);
    chk("set_hr13", tm24(), 24'h130000);
    cyc(1, 0, 0);
    chk("set_tick_blink", {23'd0, bl}, 24'd1);
    chk("set_tick_time", tm24(), 24'h130000);
    cyc(1, 0, 0);
    chk("set_tick_blink2", {23'd0, bl}, 24'd0);
    press_mode();
    chk("set_min_edit", {22'd0, ed}, 24'd2);
    press_inc(61);
    chk("set_min61", tm24(), 24'h130100);
    press_mode();
    chk("set_run_edit", {22'd0, ed}, 24'd0);
    chk("set_run_time", tm24(), 24'h130100);

    // Rollover with day_tick
    do_reset();
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(59);
    press_mode();
    ticks(58);
    chk("roll_pre", tm24(), 24'h235958);
    cyc(1, 0, 0);
    chk("roll_59", tm24(), 24'h235959);
    chk("roll_59_day", {23'd0, dt}, 24'd0);
    cyc(1, 0, 0);
    chk("roll_00", tm24(), 24'h000000);
    chk("roll_day_hi", {23'd0, dt}, 24'd1);
    cyc(0, 0, 0);
    chk("roll_day_lo", {23'd0, dt}, 24'd0);

    // Cascade over a full hour
    do_reset();
    for (int k = 1; k <= 3600; k++) begin
      cyc(1, 0, 0);
      if (k == 599)  chk("casc_0959", tm24(), 24'h000959);
      if (k == 600)  chk("casc_1000", tm24(), 24'h001000);
      if (k == 3599) chk("casc_5959", tm24(), 24'h005959);
      if (k == 3600) chk("casc_0100", tm24(), 24'h010000);
    end

    // 12-hour instance
    do_reset();
    press_mode();
    press_inc(11);
    chk("h12_set11", tm12(), 24'h110000);
    press_inc(1);
    chk("h12_wrap00", tm12(), 24'h000000);
    press_inc(11);
    press_mode();
    press_inc(59);
    press_mode();
    ticks(59);
    chk("h12_pre", tm12(), 24'h115959);
    cyc(1, 0, 0);
    chk("h12_roll", tm12(), 24'h000000);
    chk("h12_day", {23'd0, dt2}, 24'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
